// File: rtl/mux_stream_arb.sv
// N-channel stream multiplexer with a registered output stage.
// A channel is picked either by the external select (mode=0) or by a
// round-robin search among valid channels (mode=1). The output register
// accepts a new word whenever it is empty or being drained in the same cycle.
module mux_stream_arb #(
    parameter int               WIDTH   = 16,
    parameter int               N       = 9,
    parameter int               SELW    = 4,
    parameter logic [WIDTH-1:0] DEFAULT = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch,
    output logic                 sel_err
);

    // One extra bit so the comparison also works when N == 2**SELW.
    localparam logic [SELW:0]     N_EXT    = (SELW+1)'(N);
    localparam logic [SELW-1:0]   PTR_INIT = SELW'(N-1);

    logic                 load;
    logic                 grant_valid;
    logic [SELW-1:0]      grant;
    logic [WIDTH-1:0]     grant_data;
    logic                 transfer;
    logic [SELW-1:0]      ptr;
    logic                 sel_oob;

    assign load     = !out_valid || out_ready;
    assign transfer = load && grant_valid;
    assign sel_oob  = ({1'b0, sel} >= N_EXT);

    // Grant selection: direct index in manual mode, first valid channel after ptr (mod N) otherwise.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                if (sel == SELW'(k) && in_valid[k]) begin
                    grant       = SELW'(k);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                idx = int'(ptr) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                for (int k = 0; k < N; k++) begin
                    if (!grant_valid && k == idx && in_valid[k]) begin
                        grant       = SELW'(k);
                        grant_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == SELW'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready toward the granted channel; held low while in reset.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = rst_n && transfer && (grant == SELW'(k));
        end
    end

    // Output register: refill on a handshake, empty when drained with nothing to take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= DEFAULT;
            out_ch    <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer follows only arbitrated transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PTR_INIT;
        end else if (transfer && mode) begin
            ptr <= grant;
        end
    end

    // Out-of-range select flag, refreshed every cycle regardless of back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= !mode && sel_oob;
        end
    end

endmodule

// File: tb/tb_mux_stream_arb.sv
module tb_mux_stream_arb;

    localparam int WIDTH = 16;
    localparam int N     = 9;
    localparam int SELW  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;
    logic                 sel_err;

    mux_stream_arb #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_ptr;
    bit          m_valid;
    logic [15:0] m_data;
    int          m_ch;
    bit          m_err;
    logic [15:0] chdata [N];

    // Expected combinational results for the current inputs
    bit e_load;
    bit e_found;
    int e_g;
    int e_ready;

    task automatic model_reset();
        m_ptr   = N - 1;
        m_valid = 0;
        m_data  = 16'hFFFF;
        m_ch    = 0;
        m_err   = 0;
    endtask

    task automatic model_comb(input bit md, input int sl, input int vm, input bit ordy);
        e_load  = !m_valid || ordy;
        e_found = 0;
        e_g     = 0;
        if (!md) begin
            if (sl < N && ((vm >> sl) & 1) == 1) begin
                e_found = 1;
                e_g     = sl;
            end
        end else begin
            for (int i = 1; i <= N && !e_found; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (((vm >> c) & 1) == 1) begin
                    e_found = 1;
                    e_g     = c;
                end
            end
        end
        e_ready = (e_load && e_found) ? (1 << e_g) : 0;
    endtask

    task automatic check_regs(input string pfx);
        chk({pfx, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({pfx, ".out_data"},  32'(out_data),  32'(m_data));
        chk({pfx, ".out_ch"},    32'(out_ch),    32'(m_ch));
        chk({pfx, ".sel_err"},   32'(sel_err),   32'(m_err));
    endtask

    // Called at a falling edge: drive inputs, check ready, clock, check registers.
    task automatic step(input bit md, input int sl, input int vm, input bit ordy);
        for (int k = 0; k < N; k++) begin
            chdata[k] = 16'($urandom);
            in_data[k*WIDTH +: WIDTH] = chdata[k];
        end
        mode      = md;
        sel       = SELW'(sl);
        in_valid  = N'(vm);
        out_ready = ordy;
        #1;
        model_comb(md, sl, vm, ordy);
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        @(posedge clk);
        m_err = (!md && sl >= N);
        if (e_load) begin
            if (e_found) begin
                m_valid = 1;
                m_data  = chdata[e_g];
                m_ch    = e_g;
                if (md) m_ptr = e_g;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        check_regs("step");
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = '1;
        out_ready = 1'b1;
        in_data   = '0;
        model_reset();

        // Reset held with all channels valid
        repeat (3) @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'h0);
        check_regs("rst");

        rst_n = 1'b1;
        step(1, 0, 9'h1FF, 1);
        chk("first_rr_ch", 32'(out_ch), 32'd0);

        // Fairness among 2, 5, 8 with wrap 8 -> 2
        for (int i = 0; i < 6; i++) begin
            step(1, 0, (1 << 2) | (1 << 5) | (1 << 8), 1);
            chk("rr_seq", 32'(out_ch), 32'((i % 3) * 3 + 2));
        end

        // Manual select of channel 3, then out-of-range select
        step(0, 3, 1 << 3, 1);
        chk("man_ch", 32'(out_ch), 32'd3);
        step(0, 9, 9'h1FF, 1);
        chk("oob_err", 32'(sel_err), 32'd1);
        chk("oob_valid", 32'(out_valid), 32'd0);

        // Back-pressure for 3 cycles, then release
        step(1, 0, 9'h1FF, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 9'h1FF, 0);
        step(1, 0, 9'h1FF, 1);

        // Mode switch keeps ptr at 4
        step(1, 0, 1 << 4, 1);
        step(0, 1, 1 << 1, 1);
        step(0, 1, 1 << 1, 1);
        step(1, 0, (1 << 1) | (1 << 5), 1);
        chk("mode_switch_ch", 32'(out_ch), 32'd5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 511)),
                 ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges while holding a word
        step(1, 0, 9'h1FF, 0);
        step(1, 0, 9'h1FF, 0);
        chk("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("arst");
        chk("arst.in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 9'h1FF, 1);
        chk("post_arst_ch", 32'(out_ch), 32'd0);
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 15),
                 int'($urandom_range(0, 511)), $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
